// File: rtl/bus_pkg.sv
// Shared constants and types for the datapath bus arbiter/multiplexer.
package bus_pkg;

  localparam int BUS_MODE_MUX = 0;   // exclusive mux, lowest index wins
  localparam int BUS_MODE_RR  = 1;   // round-robin arbiter
  localparam int BUS_CNT_W    = 16;  // conflict counter width
  localparam int BUS_WIDTH    = 32;  // default bus width
  localparam int BUS_NUM_SRC  = 24;  // default number of bus sources

  // Bus ownership state; ST_OWNED is the owner_vld flag.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } bus_state_e;

endpackage

// File: rtl/bus_arb_mux_if.sv
// Source/consumer bundle of the datapath bus.
// Optional conflict_cnt signal exists only with BUS_ARB_CONFLICT_CNT_EN.
interface bus_arb_mux_if #(
  parameter int NUM_SRC = bus_pkg::BUS_NUM_SRC,
  parameter int WIDTH   = bus_pkg::BUS_WIDTH
);

  logic [NUM_SRC*WIDTH-1:0]     src_data;
  logic [NUM_SRC-1:0]           src_req;
  logic                         cnt_clr;
  logic [NUM_SRC-1:0]           src_gnt;
  logic [WIDTH-1:0]             bus_out;
  logic                         bus_vld;
  logic                         conflict;
`ifdef BUS_ARB_CONFLICT_CNT_EN
  logic [bus_pkg::BUS_CNT_W-1:0] conflict_cnt;
`endif

  // Sources and consumers side.
  modport master (
    output src_data, src_req, cnt_clr,
    input  src_gnt, bus_out, bus_vld, conflict
`ifdef BUS_ARB_CONFLICT_CNT_EN
    , input conflict_cnt
`endif
  );

  // Arbiter side.
  modport slave (
    input  src_data, src_req, cnt_clr,
    output src_gnt, bus_out, bus_vld, conflict
`ifdef BUS_ARB_CONFLICT_CNT_EN
    , output conflict_cnt
`endif
  );

endinterface

// File: rtl/bus_arb_mux_rr_pick.sv
// Combinational find-first-set over a request vector, starting one past
// the given pointer and wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N     = 24,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // Scan ptr+1, ptr+2, ... ptr+N (mod N); first set bit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 1; k <= N; k++) begin
      pos     = (int'(ptr_i) + k) % N;
      pos_idx = IDX_W'(pos);
      if (!found_o && req_i[pos_idx]) begin
        found_o = 1'b1;
        idx_o   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered datapath bus multiplexer / round-robin arbiter.
// MODE 0: lowest requesting index wins, multi-request cycles flagged.
// MODE 1: round-robin with optional ownership lock (LOCK).
// Define BUS_ARB_CONFLICT_CNT_EN to add the saturating conflict counter.
module bus_arb_mux
  import bus_pkg::*;
#(
  parameter int NUM_SRC = BUS_NUM_SRC,
  parameter int WIDTH   = BUS_WIDTH,
  parameter int MODE    = BUS_MODE_MUX,
  parameter int LOCK    = 1
) (
  input  logic         clk,
  input  logic         clr,
  bus_arb_mux_if.slave bus
);

  localparam int                 IDX_W    = $clog2(NUM_SRC);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SRC - 1);
  localparam logic [NUM_SRC-1:0] ONE      = NUM_SRC'(1);

  logic [WIDTH-1:0] src_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_arr[i] = bus.src_data[i*WIDTH +: WIDTH];
  end

  bus_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             vld_q, vld_d;
  logic             conflict_q, conflict_d;

  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W-1:0] win;
  logic             win_found;
  logic             lock_hit;

  // The mux mode is a plain priority search: start just past the top index.
  assign pick_ptr = (MODE == BUS_MODE_MUX) ? LAST_IDX : ptr_q;

  rr_pick #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (bus.src_req),
    .ptr_i   (pick_ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Winner selection and next-state of ownership, pointer and outputs.
  always_comb begin
    state_d    = ST_IDLE;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    bus_d      = '0;
    vld_d      = 1'b0;
    conflict_d = 1'b0;
    lock_hit   = (MODE == BUS_MODE_RR) && (LOCK != 0) &&
                 (state_q == ST_OWNED) && bus.src_req[owner_q];
    win        = lock_hit ? owner_q : pick_idx;
    win_found  = lock_hit || pick_found;

    if (MODE == BUS_MODE_MUX) begin
      conflict_d = (bus.src_req & (bus.src_req - ONE)) != '0;
    end

    if (win_found) begin
      state_d = ST_OWNED;
      owner_d = win;
      gnt_d   = ONE << win;
      bus_d   = src_arr[win];
      vld_d   = 1'b1;
      if (MODE == BUS_MODE_RR) begin
        ptr_d = win;
      end
    end
  end

  // Ownership state, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= LAST_IDX;
      gnt_q      <= '0;
      bus_q      <= '0;
      vld_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      bus_q      <= bus_d;
      vld_q      <= vld_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.src_gnt  = gnt_q;
  assign bus.bus_out  = bus_q;
  assign bus.bus_vld  = vld_q;
  assign bus.conflict = conflict_q;

`ifdef BUS_ARB_CONFLICT_CNT_EN
  logic [BUS_CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of conflict cycles; clear beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (conflict_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + BUS_CNT_W'(1);
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.conflict_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
`endif

endmodule

// File: doc/bus_arb_mux.md
# bus_arb_mux

Parametrised, registered successor to the datapath bus multiplexer. Selects one of `NUM_SRC` sources onto a `WIDTH`-bit bus and registers the result. Two modes: exclusive-select mux mode with priority resolution and conflict flagging, or round-robin arbitration with ownership lock. Sits between the register file, special registers, MDR, in-port and constant sources and every bus consumer in the datapath.

## Interface
- `NUM_SRC`, 24, number of bus sources (2..32).
- `WIDTH`, 32, bus width in bits.
- `MODE`, 0, 0 = exclusive mux with priority; 1 = round-robin arbiter.
- `LOCK`, 1, MODE 1 only: the owner keeps the grant while its request stays high.

- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `src_data`  in  NUM_SRC*WIDTH  flattened source data; source i is at [i*WIDTH +: WIDTH].
- `src_req`  in  NUM_SRC  per-source out/request strobes.
- `cnt_clr`  in  1  synchronous clear of `conflict_cnt`.
- `src_gnt`  out  NUM_SRC  registered one-hot grant, all zero when idle.
- `bus_out`  out  WIDTH  registered bus value.
- `bus_vld`  out  1  registered; high when a source owns the bus.
- `conflict`  out  1  registered one-cycle pulse for a multi-request cycle in MODE 0.
- `conflict_cnt`  out  16  saturating conflict count; present only with the macro.

## Operation
- States are IDLE and OWNED, held as `owner_vld` plus a `$clog2(NUM_SRC)`-bit `owner` index.
- Reset values: `src_gnt`=0, `bus_out`=0, `bus_vld`=0, `conflict`=0, `conflict_cnt`=0, state IDLE, RR pointer=NUM_SRC-1.
- Each edge evaluates `src_req` and picks a winner W:
  - MODE 0: W is the lowest set index. `conflict`<=1 if popcount(`src_req`)>1, else 0.
  - MODE 1, LOCK=1: if OWNED and `src_req[owner]`=1, then W=owner.
  - MODE 1, otherwise: W is the first set index searching from pointer+1 upward, wrapping past NUM_SRC-1 to 0.
  - On every MODE 1 grant, pointer<=W.
- Winner exists: state<=OWNED, `owner`<=W, `src_gnt`<=1<<W, `bus_out`<=`src_data[W]`, `bus_vld`<=1.
- No request: state<=IDLE, `src_gnt`<=0, `bus_out`<=0, `bus_vld`<=0. The pointer holds.
- Owner drops its request: re-arbitration happens on that same edge. There is no dead cycle when another request is pending.
- `conflict` is always 0 in MODE 1.
- `clr` low mid-transfer: all outputs clear immediately, without waiting for a clock edge. The first edge after `clr` releases arbitrates fresh, from pointer NUM_SRC-1.

## Timing
- Latency is 1 cycle. `src_req` and `src_data` sampled at edge n appear on `src_gnt`, `bus_out` and `bus_vld` after edge n.
- While OWNED, `bus_out` tracks the owner's data with 1-cycle latency.
- Handshake: a requester holds `src_req` until it sees its `src_gnt` bit. The bus data valid for that source is the value present on `bus_out` while its grant is high.
- No combinational path from inputs to outputs.

## Configuration
- `BUS_ARB_CONFLICT_CNT_EN` defined:
  - `conflict_cnt` port and counter exist.
  - The counter increments on each edge where `conflict` is set, and saturates at 16'hFFFF.
  - `cnt_clr` clears it on the edge; clear wins over a simultaneous increment.
- Undefined: `conflict_cnt` port and counter are removed. `cnt_clr` remains as a port but is ignored.

## Structure
- Shared package `bus_pkg`:
  - mode constants `BUS_MODE_MUX`=0 and `BUS_MODE_RR`=1;
  - `BUS_CNT_W`=16;
  - the default widths `BUS_WIDTH`=32 and `BUS_NUM_SRC`=24.
- One sub-module, `rr_pick`: combinational find-first-set starting from a given pointer, with wrap-around. It returns index plus found flag. MODE 0 uses it with pointer NUM_SRC-1.
- The top level holds state, pointer, output registers and the optional counter.

## Test plan
All scenarios use defaults NUM_SRC=24, WIDTH=32, where source i drives data 32'h100+i, except where a scenario sets MODE or NUM_SRC explicitly.
- Reset: `clr` low mid-transfer while source 5 owns the bus -> `bus_out`=0, `bus_vld`=0, `src_gnt`=0 immediately, before the next edge.
- MODE 0, single source: `src_req`=1<<22 for 3 cycles -> after each edge `bus_out`=32'h116, `src_gnt`=1<<22, `conflict`=0; one edge after the request is removed, `bus_out`=0.
- MODE 0, conflict: `src_req` bits 3 and 7 set for one cycle -> `bus_out`=32'h103, `conflict` pulses for 1 cycle; with the macro defined, `conflict_cnt`=1, and asserting `cnt_clr` in the same cycle as a conflict gives 0.
- MODE 1, LOCK=1: sources 2 and 4 request constantly -> 2 is granted first and held. When 2 drops its request, 4 is granted on the same edge. When 2 re-requests while 4 still holds, 4 keeps the grant.
- MODE 1, LOCK=0, wrap: NUM_SRC=4, all requesting -> the grant sequence is 0,1,2,3,0, one grant per cycle.
- Saturation, macro defined: force 65536 conflict cycles -> `conflict_cnt` stays at 16'hFFFF.
